// File: rtl/sort_mem_master.sv
// In-place ascending bubble sort (early exit) over a block of words in a single-port memory.
// Define SORT_SIGNED_EN to compare words as two's-complement instead of unsigned.
module sort_mem_master #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_adr,
    input  logic [CNT_W-1:0]  num,
    output logic              busy,
    output logic              done,
    output logic [15:0]       swap_cnt,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_dout
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_A, S_RD_B, S_CMP, S_WR_A, S_WR_B, S_NEXT, S_DONE
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  i_q;
    logic [CNT_W-1:0]  limit_q;
    logic              swapped_q;
    logic [DATA_W-1:0] a_q;
    logic [15:0]       swap_cnt_q;
    logic [ADDR_W-1:0] adr_q;
    logic [DATA_W-1:0] din_q;
    logic              wr_q;
    logic              rd_q;
    logic              busy_q;
    logic              done_q;

    logic [ADDR_W-1:0] adr_i;
    logic [ADDR_W-1:0] adr_i1;
    logic              last_pair;
    logic              a_gt_b;

    // Addresses wrap modulo 2^ADDR_W; the memory only decodes the low bits.
    assign adr_i     = base_q + ADDR_W'(i_q);
    assign adr_i1    = adr_i + ADDR_W'(1);
    assign last_pair = (i_q + CNT_W'(1)) >= limit_q;

`ifdef SORT_SIGNED_EN
    assign a_gt_b = $signed(a_q) > $signed(mem_dout);
`else
    assign a_gt_b = a_q > mem_dout;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            swap_cnt_q <= '0;
            adr_q      <= '0;
            din_q      <= '0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            swapped_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            wr_q   <= 1'b0;
            rd_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        base_q     <= base_adr;
                        swap_cnt_q <= '0;
                        i_q        <= '0;
                        limit_q    <= num - CNT_W'(1);
                        swapped_q  <= 1'b0;
                        if (num < CNT_W'(2)) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_RD_A;
                            busy_q  <= 1'b1;
                            rd_q    <= 1'b1;
                            adr_q   <= base_adr;
                        end
                    end
                end
                S_RD_A: begin
                    state_q <= S_RD_B;
                    rd_q    <= 1'b1;
                    adr_q   <= adr_i1;
                end
                S_RD_B: begin
                    // Read data lags the address by one cycle, so word i is visible now.
                    a_q     <= mem_dout;
                    state_q <= S_CMP;
                end
                S_CMP: begin
                    if (a_gt_b) begin
                        state_q <= S_WR_A;
                        wr_q    <= 1'b1;
                        adr_q   <= adr_i;
                        din_q   <= mem_dout;
                    end else begin
                        state_q <= S_NEXT;
                    end
                end
                S_WR_A: begin
                    state_q <= S_WR_B;
                    wr_q    <= 1'b1;
                    adr_q   <= adr_i1;
                    din_q   <= a_q;
                end
                S_WR_B: begin
                    swapped_q <= 1'b1;
                    if (swap_cnt_q != 16'hFFFF)
                        swap_cnt_q <= swap_cnt_q + 16'd1;
                    state_q <= S_NEXT;
                end
                S_NEXT: begin
                    if (!last_pair) begin
                        i_q     <= i_q + CNT_W'(1);
                        state_q <= S_RD_A;
                        rd_q    <= 1'b1;
                        adr_q   <= adr_i1;
                    end else if (!swapped_q || limit_q == CNT_W'(1)) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        // Largest remaining word has bubbled to the end; shrink the pass.
                        limit_q   <= limit_q - CNT_W'(1);
                        i_q       <= '0;
                        swapped_q <= 1'b0;
                        state_q   <= S_RD_A;
                        rd_q      <= 1'b1;
                        adr_q     <= base_q;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign swap_cnt  = swap_cnt_q;
    assign mem_adr   = adr_q;
    assign mem_din   = din_q;
    assign mem_wr_en = wr_q;
    assign mem_rd_en = rd_q;

endmodule

// File: tb/tb_sort_mem_master.sv
// Scoreboard bench for sort_mem_master with a 1-cycle-latency 1024-word memory model.
// Reference results come from rank/inversion counting, not from stepping a bubble sort.
`timescale 1ns/1ps
module tb_sort_mem_master;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 11;
    localparam int MAXN   = 16;
    localparam int MAXJ   = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_adr;
    logic [CNT_W-1:0]  num;
    logic              busy, done;
    logic [15:0]       swap_cnt;
    logic [ADDR_W-1:0] mem_adr;
    logic [DATA_W-1:0] mem_din, mem_dout;
    logic              mem_wr_en, mem_rd_en;

    always #5 clk = ~clk;

    sort_mem_master #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .base_adr(base_adr), .num(num),
        .busy(busy), .done(done), .swap_cnt(swap_cnt), .mem_adr(mem_adr),
        .mem_din(mem_din), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
        .mem_dout(mem_dout)
    );

    // Memory model; the bench preloads through its own port while the DUT is idle.
    logic [31:0] mem [0:1023];
    logic        pl_en = 1'b0;
    logic [9:0]  pl_adr;
    logic [31:0] pl_dat;
    always @(posedge clk) begin
        if (pl_en) mem[pl_adr] <= pl_dat;
        else if (mem_wr_en) mem[mem_adr[9:0]] <= mem_din;
        if (mem_rd_en) mem_dout <= mem[mem_adr[9:0]];
    end

    int   cyc = 0;
    logic rst_at_edge = 1'b0;
    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= reset;
    end

    // Scoreboard storage, written by the driver at issue time
    logic [9:0]  exp_base [MAXJ];
    int          exp_n    [MAXJ];
    int          exp_sw   [MAXJ];
    int          exp_lat  [MAXJ];
    int          exp_start[MAXJ];
    logic [31:0] exp_w    [MAXJ][MAXN];
    bit          aborted  [MAXJ];
    int          n_issued  = 0;
    int          exp_dones = 0;
    int          timeouts  = 0;
    bit          end_req   = 1'b0;

    // Monitor-owned state
    int vectors = 0, miscompares = 0;
    int n_chk = 0, dones_ok = 0, timeouts_seen = 0;
    int rd_seen = 0, wr_seen = 0;
    bit prev_done = 1'b0, fin_done = 1'b0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endfunction

    function automatic bit gt(logic [31:0] x, logic [31:0] y);
`ifdef SORT_SIGNED_EN
        return $signed(x) > $signed(y);
`else
        return x > y;
`endif
    endfunction

    always @(negedge clk) begin
        int id;
        if (rst_at_edge) begin
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_swap_cnt", swap_cnt, 0);
            chk("rst_mem_adr", mem_adr, 0);
            chk("rst_mem_din", mem_din, 0);
            chk("rst_wr_en", mem_wr_en, 0);
            chk("rst_rd_en", mem_rd_en, 0);
        end
        if (mem_rd_en || mem_wr_en) begin
            chk("strobe_exclusive", mem_rd_en & mem_wr_en, 0);
            chk("busy_with_strobe", busy, 1);
        end
        if (reset) begin
            rd_seen = 0;
            wr_seen = 0;
        end else begin
            rd_seen += int'(mem_rd_en);
            wr_seen += int'(mem_wr_en);
        end
        if (timeouts != timeouts_seen) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_bound: %0d waits expired, required 0", timeouts);
            timeouts_seen = timeouts;
        end
        if (done) begin
            chk("done_single_cycle", prev_done, 0);
            while (n_chk < n_issued && aborted[n_chk]) n_chk++;
            if (n_chk >= n_issued) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: done=1 with no job pending, required 0");
            end else begin
                id = n_chk;
                n_chk++;
                for (int k = 0; k < exp_n[id]; k++)
                    chk($sformatf("job%0d_word%0d", id, k),
                        mem[exp_base[id] + 10'(k)], exp_w[id][k]);
                chk($sformatf("job%0d_swap_cnt", id), swap_cnt, 64'(exp_sw[id]));
                chk($sformatf("job%0d_busy_at_done", id), busy, 0);
                if (exp_lat[id] >= 0)
                    chk($sformatf("job%0d_latency", id), 64'(cyc - exp_start[id] + 1), 64'(exp_lat[id]));
                if (exp_n[id] < 2)
                    chk($sformatf("job%0d_rd_strobes", id), 64'(rd_seen), 0);
                if (exp_sw[id] == 0)
                    chk($sformatf("job%0d_wr_strobes", id), 64'(wr_seen), 0);
                rd_seen  = 0;
                wr_seen  = 0;
                dones_ok++;
            end
        end
        if (end_req && !fin_done) begin
            chk("jobs_completed", 64'(dones_ok), 64'(exp_dones));
            fin_done = 1'b1;
        end
        prev_done = done;
    end

    logic [31:0] buf_w [MAXN];

    task automatic issue(input logic [9:0] base, input int n, input bit preload);
        int id, inv, r;
        logic [31:0] hi;
        if (preload) begin
            for (int k = 0; k < n; k++) begin
                @(negedge clk);
                pl_en  = 1'b1;
                pl_adr = base + 10'(k);
                pl_dat = buf_w[k];
            end
            @(negedge clk);
            pl_en = 1'b0;
        end else begin
            for (int k = 0; k < n; k++) buf_w[k] = mem[base + 10'(k)];
            @(negedge clk);
        end
        id  = n_issued;
        inv = 0;
        for (int a = 0; a < n; a++)
            for (int b = a + 1; b < n; b++)
                if (gt(buf_w[a], buf_w[b])) inv++;
        // Final position = count of strictly smaller words + count of equal words earlier.
        for (int a = 0; a < n; a++) begin
            r = 0;
            for (int b = 0; b < n; b++)
                if (gt(buf_w[a], buf_w[b]) || (b < a && buf_w[b] == buf_w[a])) r++;
            exp_w[id][r] = buf_w[a];
        end
        exp_base[id]  = base;
        exp_n[id]     = n;
        exp_sw[id]    = (inv > 65535) ? 65535 : inv;
        exp_lat[id]   = (n < 2) ? 1 : ((inv == 0) ? (n - 1) * 4 + 1 : -1);
        exp_start[id] = cyc + 1;
        aborted[id]   = 1'b0;
        n_issued++;
        exp_dones++;
        hi       = $urandom;
        base_adr = {hi[21:0], base};
        num      = CNT_W'(n);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_jobs();
        int t = 0;
        while (dones_ok < exp_dones && t < 4000) begin
            @(negedge clk);
            t++;
        end
        if (dones_ok < exp_dones) timeouts++;
        @(negedge clk);
    endtask

    initial begin
        int t;
        int n;
        logic [31:0] rv;
        reset    = 1'b1;
        start    = 1'b0;
        base_adr = '0;
        num      = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        buf_w[0] = 5; buf_w[1] = 3; buf_w[2] = 8; buf_w[3] = 1;
        issue(10'h000, 4, 1'b1);
        wait_jobs();

        for (int k = 0; k < 8; k++) buf_w[k] = 32'(k + 1);
        issue(10'h040, 8, 1'b1);
        wait_jobs();

        issue(10'h080, 0, 1'b1);
        wait_jobs();
        buf_w[0] = 32'h9;
        issue(10'h080, 1, 1'b1);
        wait_jobs();

        buf_w[0] = 4; buf_w[1] = 3; buf_w[2] = 2; buf_w[3] = 1;
        issue(10'h3FE, 4, 1'b1);
        wait_jobs();

        buf_w[0] = 32'hFFFF_FFFF; buf_w[1] = 32'h1;
        issue(10'h090, 2, 1'b1);
        wait_jobs();

        // Abort mid-swap: reset lands on the second write cycle of the first swap.
        buf_w[0] = 5; buf_w[1] = 3; buf_w[2] = 8; buf_w[3] = 1;
        issue(10'h020, 4, 1'b1);
        t = 0;
        while (!mem_wr_en && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!mem_wr_en) timeouts++;
        @(negedge clk);
        reset = 1'b1;
        aborted[n_issued - 1] = 1'b1;
        exp_dones--;
        @(negedge clk);
        reset = 1'b0;
        issue(10'h020, 4, 1'b0);
        repeat (5) @(negedge clk);
        base_adr = 32'h100;
        num      = CNT_W'(5);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_jobs();

        for (int j = 0; j < 20; j++) begin
            n  = $urandom_range(0, 12);
            rv = $urandom;
            for (int k = 0; k < n; k++)
                buf_w[k] = rv[0] ? 32'($urandom_range(0, 5)) : $urandom;
            issue(rv[10:1], n, 1'b1);
            wait_jobs();
        end

        repeat (5) @(negedge clk);
        end_req = 1'b1;
        t = 0;
        while (!fin_done && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!fin_done) begin
            $display("FAIL monitor_final: monitor did not finish, required finish");
            $fatal(1, "monitor stalled");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
